// File: rtl/inv_key_schedule.sv
// AES-128 inverse key schedule: walks from the round-10 key back to round 0, one key per handshake.
// Optional round-0 self-check against cipherKey is enabled by defining AES_INVKEY_CHECK_EN.
//
// state | meaning
// IDLE  | waiting for start
// EMIT  | key presented, waiting for the handshake
// DONE  | one cycle, done=1
module inv_key_schedule (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] lastKey,
    input  logic         keyReady,
`ifdef AES_INVKEY_CHECK_EN
    input  logic [127:0] cipherKey,
    output logic         keyMatch,
`endif
    output logic         keyValid,
    output logic [127:0] roundKey,
    output logic [3:0]   roundNum,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state, state_nxt;
    logic [127:0] key_nxt;
    logic [3:0]   round_nxt;
    logic         key_hs;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ ({8{aa[7]}} & 8'h1b);
        end
        return p;
    endfunction

    // S-box as multiplicative inverse (x^254) followed by the affine transform
    function automatic logic [7:0] sub_byte(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] r;
        p = x;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
                 ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] c;
        case (r)
            4'd1:    c = 8'h01;
            4'd2:    c = 8'h02;
            4'd3:    c = 8'h04;
            4'd4:    c = 8'h08;
            4'd5:    c = 8'h10;
            4'd6:    c = 8'h20;
            4'd7:    c = 8'h40;
            4'd8:    c = 8'h80;
            4'd9:    c = 8'h1b;
            4'd10:   c = 8'h36;
            default: c = 8'h00;
        endcase
        return c;
    endfunction

    function automatic logic [127:0] inv_step(input logic [127:0] k, input logic [3:0] r);
        logic [31:0] n0, n1, n2, n3, rot, sw;
        n3  = k[31:0]  ^ k[63:32];
        n2  = k[63:32] ^ k[95:64];
        n1  = k[95:64] ^ k[127:96];
        rot = {n3[23:0], n3[31:24]};
        sw  = {sub_byte(rot[31:24]), sub_byte(rot[23:16]),
               sub_byte(rot[15:8]),  sub_byte(rot[7:0])};
        n0  = k[127:96] ^ sw ^ {rcon(r), 24'h000000};
        return {n0, n1, n2, n3};
    endfunction

    assign key_hs = (state == EMIT) && keyReady;

    always_comb begin
        state_nxt = state;
        key_nxt   = roundKey;
        round_nxt = roundNum;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = EMIT;
                    key_nxt   = lastKey;
                    round_nxt = 4'd10;
                end
            end
            EMIT: begin
                if (key_hs) begin
                    if (roundNum != 4'd0) begin
                        key_nxt   = inv_step(roundKey, roundNum);
                        round_nxt = roundNum - 4'd1;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            keyValid <= 1'b0;
            roundKey <= '0;
            roundNum <= 4'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            roundKey <= key_nxt;
            roundNum <= round_nxt;
            keyValid <= (state_nxt == EMIT);
            busy     <= (state_nxt != IDLE);
            done     <= (state_nxt == DONE);
        end
    end

`ifdef AES_INVKEY_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            keyMatch <= 1'b0;
        end else if ((state == IDLE) && start) begin
            keyMatch <= 1'b0;
        end else if (key_hs && (roundNum == 4'd0)) begin
            keyMatch <= (roundKey == cipherKey);
        end
    end
`endif

endmodule

// File: tb/tb_inv_key_schedule.sv
// Directed bench for inv_key_schedule using FIPS-197 A.1 and C.1 key expansions.
// Build with AES_INVKEY_CHECK_EN defined to also exercise keyMatch.
module tb_inv_key_schedule;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [127:0] lastKey;
    logic         keyReady;
    logic         keyValid;
    logic [127:0] roundKey;
    logic [3:0]   roundNum;
    logic         busy;
    logic         done;
`ifdef AES_INVKEY_CHECK_EN
    logic [127:0] cipherKey;
    logic         keyMatch;
`endif

    int n_checks;
    int n_pass;

    localparam logic [127:0] A1_LAST = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] A1_R0   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C1_LAST = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    logic [127:0] c1_keys [0:10];

    inv_key_schedule dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .lastKey  (lastKey),
        .keyReady (keyReady),
`ifdef AES_INVKEY_CHECK_EN
        .cipherKey(cipherKey),
        .keyMatch (keyMatch),
`endif
        .keyValid (keyValid),
        .roundKey (roundKey),
        .roundNum (roundNum),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full C.1 walk; optional random backpressure and ignored start pokes
    task automatic run_c1(input bit rand_ready, input bit poke_start);
        int           exp_rnd;
        bit           fin;
        bit           rdy;
        logic [127:0] prev_key;
        logic [3:0]   prev_rnd;
        lastKey  = C1_LAST;
        start    = 1'b1;
        keyReady = 1'b1;
        tick();
        start   = 1'b0;
        exp_rnd = 10;
        fin     = 1'b0;
        for (int it = 0; it < 200 && !fin; it++) begin
            check("c1_valid", keyValid, 1'b1);
            check("c1_num", roundNum, exp_rnd[3:0]);
            check("c1_key", roundKey, c1_keys[exp_rnd]);
            check("c1_nodone", done, 1'b0);
            rdy      = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            keyReady = rdy;
            if (poke_start && (exp_rnd == 10 || exp_rnd == 5 || exp_rnd == 0)) begin
                start   = 1'b1;
                lastKey = A1_LAST;
            end
            prev_key = roundKey;
            prev_rnd = roundNum;
            tick();
            start = 1'b0;
            if (rdy) begin
                if (exp_rnd == 0) fin = 1'b1;
                else exp_rnd--;
            end else begin
                check("stall_key", roundKey, prev_key);
                check("stall_num", prev_rnd, roundNum);
                check("stall_nodone", done, 1'b0);
            end
        end
        if (!fin) check("c1_timeout", 1'b0, 1'b1);
        check("c1_done", done, 1'b1);
        check("c1_done_busy", busy, 1'b1);
        check("c1_done_novalid", keyValid, 1'b0);
        tick();
        check("c1_idle_done", done, 1'b0);
        check("c1_idle_busy", busy, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        c1_keys[0]  = 128'h000102030405060708090a0b0c0d0e0f;
        c1_keys[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
        c1_keys[2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
        c1_keys[3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
        c1_keys[4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
        c1_keys[5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
        c1_keys[6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
        c1_keys[7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
        c1_keys[8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
        c1_keys[9]  = 128'h549932d1f08557681093ed9cbe2c974e;
        c1_keys[10] = C1_LAST;

        rst_n    = 1'b0;
        start    = 1'b0;
        lastKey  = '0;
        keyReady = 1'b0;
`ifdef AES_INVKEY_CHECK_EN
        cipherKey = '0;
`endif
        tick();
        tick();
        check("rst_valid", keyValid, 1'b0);
        check("rst_key", roundKey, 128'h0);
        check("rst_num", roundNum, 4'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
`ifdef AES_INVKEY_CHECK_EN
        check("rst_match", keyMatch, 1'b0);
`endif
        rst_n = 1'b1;
        tick();

        // FIPS-197 A.1: exact cycle timing with keyReady held high
        keyReady = 1'b1;
        lastKey  = A1_LAST;
        start    = 1'b1;
        tick();
        start   = 1'b0;
        lastKey = C1_LAST;
        check("a1_t1_valid", keyValid, 1'b1);
        check("a1_t1_num", roundNum, 4'd10);
        check("a1_t1_key", roundKey, A1_LAST);
        check("a1_t1_busy", busy, 1'b1);
        for (int i = 0; i < 10; i++) tick();
        check("a1_t11_num", roundNum, 4'd0);
        check("a1_t11_key", roundKey, A1_R0);
        check("a1_t11_nodone", done, 1'b0);
        tick();
        check("a1_t12_done", done, 1'b1);
        check("a1_t12_valid", keyValid, 1'b0);
        tick();
        check("a1_t13_done", done, 1'b0);
        check("a1_t13_busy", busy, 1'b0);

        run_c1(1'b0, 1'b1);
        run_c1(1'b1, 1'b0);
        run_c1(1'b1, 1'b1);

        // Reset while roundNum=6
        keyReady = 1'b1;
        lastKey  = C1_LAST;
        start    = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("pre_rst_num", roundNum, 4'd6);
        check("pre_rst_key", roundKey, c1_keys[6]);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", keyValid, 1'b0);
        check("mid_rst_key", roundKey, 128'h0);
        check("mid_rst_num", roundNum, 4'd0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_done", done, 1'b0);
        tick();
        tick();
        check("rst_hold_done", done, 1'b0);
        rst_n = 1'b1;
        tick();
        check("post_rst_done", done, 1'b0);
        check("post_rst_valid", keyValid, 1'b0);
        lastKey = A1_LAST;
        start   = 1'b1;
        tick();
        start = 1'b0;
        check("restart_num", roundNum, 4'd10);
        check("restart_key", roundKey, A1_LAST);
        for (int i = 0; i < 12; i++) tick();
        check("restart_idle", busy, 1'b0);

`ifdef AES_INVKEY_CHECK_EN
        cipherKey = c1_keys[0];
        run_c1(1'b0, 1'b0);
        check("match_hi", keyMatch, 1'b1);
        cipherKey = c1_keys[0] ^ 128'h1;
        lastKey   = C1_LAST;
        start     = 1'b1;
        tick();
        start = 1'b0;
        check("match_clr", keyMatch, 1'b0);
        for (int i = 0; i < 11; i++) tick();
        check("match_lo_done", done, 1'b1);
        check("match_lo", keyMatch, 1'b0);
        tick();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
